bpred_table: RTL and testbench
==============================

BPRED_TABLE -- requirements
Module: bpred_table

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of predictor entries (power of two, 2..256).
REQ-002 SHALL have parameter CNT_BITS, default 2, saturating-counter width (1..4).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port fetchPc  input  32  fetch-stage PC to look up.
REQ-006 SHALL have port fetchHit  output  1  predict taken for fetchPc.
REQ-007 SHALL have port fetchTarget  output  32  predicted target for fetchPc.
REQ-008 SHALL have port exBranch  input  1  execute stage resolves a PC-relative branch/jump this cycle.
REQ-009 SHALL have port exPc  input  32  PC of the resolving instruction.
REQ-010 SHALL have port exTaken  input  1  resolved direction.
REQ-011 SHALL have port exTarget  input  32  resolved taken target.
REQ-012 SHALL have port exPredTaken  input  1  prediction carried down the pipe for that instruction.
REQ-013 SHALL have port perfBranches  output  32  count of resolved branches.
REQ-014 SHALL have port perfMispredicts  output  32  count of mispredicted branches.

Function
REQ-015 SHALL form IDX = log2(ENTRIES); index = pc[IDX+1:2]; tag = pc[31:IDX+2].
REQ-016 SHALL hold per entry: valid, tag, 32-bit target, CNT_BITS counter.
REQ-017 SHALL drive fetchHit combinationally = valid & tag match & counter MSB; fetchTarget = stored target when fetchHit, else 0.
REQ-018 On exBranch=1 with entry hit (valid & tag match): counter +1 saturating at all-ones if exTaken, -1 saturating at 0 if not; target <= exTarget only when exTaken.
REQ-019 On exBranch=1 with miss and exTaken=1: allocate/replace entry; valid=1, tag, target=exTarget, counter=2^(CNT_BITS-1) (weakly taken).
REQ-020 On exBranch=1 with miss and exTaken=0: no table change.
REQ-021 exBranch=0: no table change.
REQ-022 Update latency one cycle: lookup in the same cycle as an update to the same index SHALL return pre-update contents; result visible from next cycle.
REQ-023 Aliasing PCs (same index, different tag) SHALL miss and SHALL replace on taken allocation.
REQ-024 Inputs exPc[1:0], fetchPc[1:0] SHALL be ignored.

Reset
REQ-025 On rst=1 at clk edge: all valid bits, counters, targets and perf counters SHALL clear to 0; fetchHit=0, fetchTarget=0 from next cycle.
REQ-026 rst SHALL dominate a concurrent exBranch update; reset mid-operation discards it.

Configuration
REQ-027 Macro BPRED_PERF_EN defined: perfBranches +1 per exBranch=1 cycle; perfMispredicts +1 when exBranch=1 and exPredTaken!=exTaken; both wrap modulo 2^32.
REQ-028 Macro BPRED_PERF_EN undefined: no counter registers; perfBranches and perfMispredicts tied to 0; ports still present.

Verification (ENTRIES=16, CNT_BITS=2)
REQ-029 Reset, fetchPc=0x100 -> fetchHit=0, fetchTarget=0x0.
REQ-030 exBranch=1, exPc=0x100, exTaken=1, exTarget=0x200; next cycle fetchPc=0x100 -> fetchHit=1, fetchTarget=0x200 (counter=2).
REQ-031 After REQ-030, fetchPc=0x140 (same index, other tag) -> fetchHit=0; taken update at 0x140 target 0x300 -> 0x100 then misses, 0x140 hits 0x300.
REQ-032 Counter walk at 0x100: not-taken x3 -> fetchHit 0 after first, counter floors at 0; taken x4 -> hit after second, counter saturates at 3.
REQ-033 Same-cycle: fetchPc=exPc=0x100, counter=2, exTaken=0 -> fetchHit=1 that cycle, 0 next cycle.
REQ-034 5 branches, 2 with exPredTaken!=exTaken -> perfBranches=5, perfMispredicts=2 with BPRED_PERF_EN; both 0 without; rst clears to 0.

Source files
------------

// File: rtl/bpred_table.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Optional branch/mispredict performance counters are built when BPRED_PERF_EN is defined.
module bpred_table #(
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetchPc,
  output logic        fetchHit,
  output logic [31:0] fetchTarget,
  input  logic        exBranch,
  input  logic [31:0] exPc,
  input  logic        exTaken,
  input  logic [31:0] exTarget,
  input  logic        exPredTaken,
  output logic [31:0] perfBranches,
  output logic [31:0] perfMispredicts
);

  localparam int IDX   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int TAG_W = 30 - IDX;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1 << (CNT_BITS - 1));

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

  logic [IDX-1:0]      fIdx, exIdx;
  logic [TAG_W-1:0]    fTag, exTag;
  logic                exHit;
  logic                upd_d;
  logic [CNT_BITS-1:0] cnt_d;
  logic [31:0]         target_d;

  assign fIdx  = fetchPc[IDX+1:2];
  assign fTag  = fetchPc[31:IDX+2];
  assign exIdx = exPc[IDX+1:2];
  assign exTag = exPc[31:IDX+2];
  assign exHit = valid_q[exIdx] && (tag_q[exIdx] == exTag);

  // Lookup reads registered state only, so a same-cycle update is not forwarded.
  always_comb begin
    fetchHit    = valid_q[fIdx] && (tag_q[fIdx] == fTag) && cnt_q[fIdx][CNT_BITS-1];
    fetchTarget = fetchHit ? target_q[fIdx] : 32'h0;
  end

  always_comb begin
    upd_d    = 1'b0;
    cnt_d    = cnt_q[exIdx];
    target_d = target_q[exIdx];
    if (exBranch) begin
      if (exHit) begin
        upd_d = 1'b1;
        if (exTaken) begin
          target_d = exTarget;
          if (cnt_q[exIdx] != CNT_MAX) cnt_d = cnt_q[exIdx] + 1'b1;
        end else if (cnt_q[exIdx] != '0) begin
          cnt_d = cnt_q[exIdx] - 1'b1;
        end
      end else if (exTaken) begin
        // Taken miss allocates (or evicts an alias) as weakly taken.
        upd_d    = 1'b1;
        cnt_d    = CNT_WEAK;
        target_d = exTarget;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'h0;
        cnt_q[i]    <= '0;
      end
    end else if (upd_d) begin
      valid_q[exIdx]  <= 1'b1;
      tag_q[exIdx]    <= exTag;
      target_q[exIdx] <= target_d;
      cnt_q[exIdx]    <= cnt_d;
    end
  end

`ifdef BPRED_PERF_EN
  logic [31:0] perfBr_q, perfBr_d;
  logic [31:0] perfMis_q, perfMis_d;

  always_comb begin
    perfBr_d  = perfBr_q;
    perfMis_d = perfMis_q;
    if (exBranch) begin
      perfBr_d = perfBr_q + 32'd1;
      if (exPredTaken != exTaken) perfMis_d = perfMis_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perfBr_q  <= 32'h0;
      perfMis_q <= 32'h0;
    end else begin
      perfBr_q  <= perfBr_d;
      perfMis_q <= perfMis_d;
    end
  end

  assign perfBranches    = perfBr_q;
  assign perfMispredicts = perfMis_q;

  logic unusedBits;
  assign unusedBits = ^{fetchPc[1:0], exPc[1:0]};
`else
  assign perfBranches    = 32'h0;
  assign perfMispredicts = 32'h0;

  logic unusedBits;
  assign unusedBits = ^{fetchPc[1:0], exPc[1:0], exPredTaken};
`endif

endmodule

// File: tb/tb_bpred_table.sv
// Scoreboard bench for bpred_table (ENTRIES=16, CNT_BITS=2); driver queues expectations,
// a negedge monitor pops and compares them. Perf expectations follow BPRED_PERF_EN.
module tb_bpred_table;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fetchPc = 32'h0;
  logic        fetchHit;
  logic [31:0] fetchTarget;
  logic        exBranch = 1'b0;
  logic [31:0] exPc = 32'h0;
  logic        exTaken = 1'b0;
  logic [31:0] exTarget = 32'h0;
  logic        exPredTaken = 1'b0;
  logic [31:0] perfBranches;
  logic [31:0] perfMispredicts;

`ifdef BPRED_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  typedef struct {
    string       name;
    logic        expHit;
    logic [31:0] expTgt;
    logic [31:0] expBr;
    logic [31:0] expMis;
  } chk_t;

  chk_t sbQ[$];
  bit   chkEn = 1'b0;
  int   checkCnt = 0;
  int   passCnt = 0;
  int   modelBr = 0;
  int   modelMis = 0;

  bpred_table #(.ENTRIES(16), .CNT_BITS(2)) dut (
    .clk(clk), .rst(rst),
    .fetchPc(fetchPc), .fetchHit(fetchHit), .fetchTarget(fetchTarget),
    .exBranch(exBranch), .exPc(exPc), .exTaken(exTaken), .exTarget(exTarget),
    .exPredTaken(exPredTaken),
    .perfBranches(perfBranches), .perfMispredicts(perfMispredicts)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus; expectation describes outputs seen before this cycle's edge.
  task automatic applyStimulus(input logic r, input logic [31:0] fpc, input logic exb,
                               input logic [31:0] epc, input logic tk, input logic [31:0] tgt,
                               input logic pt, input bit doChk, input logic eh,
                               input logic [31:0] et, input string nm);
    chk_t c;
    @(posedge clk);
    #1;
    rst = r; fetchPc = fpc; exBranch = exb; exPc = epc;
    exTaken = tk; exTarget = tgt; exPredTaken = pt; chkEn = doChk;
    if (doChk) begin
      c.name   = nm;
      c.expHit = eh;
      c.expTgt = et;
      c.expBr  = PERF_ON ? 32'(modelBr) : 32'h0;
      c.expMis = PERF_ON ? 32'(modelMis) : 32'h0;
      sbQ.push_back(c);
    end
    if (r) begin
      modelBr = 0; modelMis = 0;
    end else if (exb) begin
      modelBr++;
      if (pt != tk) modelMis++;
    end
  endtask

  task automatic checkOutput(input chk_t c);
    checkCnt++;
    if (fetchHit === c.expHit && fetchTarget === c.expTgt) passCnt++;
    else $display("[TB] FAIL %s: hit=%b target=%h, required hit=%b target=%h",
                  c.name, fetchHit, fetchTarget, c.expHit, c.expTgt);
    checkCnt++;
    if (perfBranches === c.expBr && perfMispredicts === c.expMis) passCnt++;
    else $display("[TB] FAIL %s_perf: br=%0d mis=%0d, required br=%0d mis=%0d",
                  c.name, perfBranches, perfMispredicts, c.expBr, c.expMis);
  endtask

  // Monitor: compares whenever the driver marks the cycle as observable.
  always @(negedge clk) begin
    if (chkEn) begin
      if (sbQ.size() == 0) begin
        checkCnt++;
        $display("[TB] FAIL sb_underflow: queue empty, required 1 entry");
      end else begin
        checkOutput(sbQ.pop_front());
      end
    end
  end

  initial begin
    int wait_cnt;
    //            rst  fetchPc     exB  exPc        tk   exTarget    pt   chk  hit  target
    applyStimulus(1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   "rst0");
    applyStimulus(1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   "rst1");
    applyStimulus(0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 0, 32'h0,   "reset_state");
    applyStimulus(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 0, 32'h0,   "alloc_same_cycle");
    applyStimulus(0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h200, "alloc_visible");
    applyStimulus(0, 32'h140, 1, 32'h140, 1, 32'h300, 0, 1, 0, 32'h0,   "alias_miss");
    applyStimulus(0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 0, 32'h0,   "alias_evicted");
    applyStimulus(0, 32'h140, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h300, "alias_hit");
    applyStimulus(0, 32'h140, 1, 32'h102, 1, 32'h200, 1, 1, 1, 32'h300, "realloc_lowbits");
    applyStimulus(0, 32'h103, 1, 32'h100, 0, 32'h0,   1, 1, 1, 32'h200, "same_cycle_nt");
    applyStimulus(0, 32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 0, 32'h0,   "nt_cnt1");
    applyStimulus(0, 32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 0, 32'h0,   "nt_cnt0");
    applyStimulus(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 0, 32'h0,   "floor_cnt0");
    applyStimulus(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 0, 32'h0,   "tk_cnt1");
    applyStimulus(0, 32'h100, 1, 32'h100, 1, 32'h200, 1, 1, 1, 32'h200, "tk_cnt2");
    applyStimulus(0, 32'h100, 1, 32'h100, 1, 32'h280, 1, 1, 1, 32'h200, "tk_cnt3");
    applyStimulus(0, 32'h100, 1, 32'h100, 0, 32'h0,   1, 1, 1, 32'h280, "sat_cnt3");
    applyStimulus(0, 32'h100, 1, 32'h100, 0, 32'h0,   1, 1, 1, 32'h280, "nt_cnt2");
    applyStimulus(0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 0, 32'h0,   "nt_cnt1_miss");
    // Reset concurrent with a taken update must discard the update.
    applyStimulus(1, 32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 0, 32'h0,   "rst_mid");
    applyStimulus(0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 0, 32'h0,   "rst_dominates");
    applyStimulus(0, 32'h400, 1, 32'h400, 0, 32'h0,   0, 1, 0, 32'h0,   "perf_b1");
    applyStimulus(0, 32'h400, 1, 32'h404, 0, 32'h0,   1, 1, 0, 32'h0,   "perf_b2");
    applyStimulus(0, 32'h400, 1, 32'h408, 0, 32'h0,   0, 1, 0, 32'h0,   "perf_b3");
    applyStimulus(0, 32'h400, 1, 32'h40c, 0, 32'h0,   1, 1, 0, 32'h0,   "perf_b4");
    applyStimulus(0, 32'h400, 1, 32'h410, 0, 32'h0,   0, 1, 0, 32'h0,   "perf_b5");
    applyStimulus(0, 32'h400, 0, 32'h0,   0, 32'h0,   0, 1, 0, 32'h0,   "perf_total");
    applyStimulus(1, 32'h400, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   "perf_rst");
    applyStimulus(0, 32'h400, 0, 32'h0,   0, 32'h0,   0, 1, 0, 32'h0,   "perf_cleared");
    applyStimulus(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   "idle");

    wait_cnt = 0;
    while (sbQ.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (sbQ.size() != 0) begin
      checkCnt++;
      $display("[TB] FAIL sb_drain: %0d entries left, required 0", sbQ.size());
    end
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
